// File: rtl/pdh_pkg.sv
// -----------------------------------------------------------------------------
// pdh_pkg
//   Shared definitions for the capture read-side engine.
//   - reader_state_t : FSM encoding of bram_stream_reader
//   - DATA_W         : BRAM word / stream data width
//   - BRAM_RD_LAT    : BRAM read latency in cycles (address to data)
// -----------------------------------------------------------------------------
package pdh_pkg;

  localparam int DATA_W      = 64;
  localparam int BRAM_RD_LAT = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_STREAM = 2'b01,
    ST_DRAIN  = 2'b10,
    ST_DONE   = 2'b11
  } reader_state_t;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for slow level signals crossing into clk.
//   Ports:
//     clk    in   destination clock
//     rst_ni in   asynchronous active-low reset (outputs clear to 0)
//     d      in   WIDTH-bit asynchronous input
//     q      out  WIDTH-bit synchronized output
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_r <= {WIDTH{1'b0}};
      sync_r <= {WIDTH{1'b0}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/bram_stream_reader.sv
// -----------------------------------------------------------------------------
// bram_stream_reader
//   Sweeps the capture BRAM from address 0 to DEPTH-1 once per capture and
//   presents each word as an AXI-Stream beat. Raises dma_done_o after the
//   tlast handshake and holds it until the enable level falls (4-phase).
//   Dropping the enable mid-capture aborts: the current head beat is still
//   delivered (with tlast forced), everything else is discarded.
//
//   Optional feature macro: BRAM_READER_STALL_CNT_EN
//     adds stall_cnt_o, a saturating count of tvalid & !tready cycles for the
//     current capture, cleared when a new capture starts.
//
//   Ports:
//     axi_clk        in   sole clock (also the BRAM read clock)
//     rst_ni         in   asynchronous active-low reset
//     dma_enable_i   in   capture-ready level from the pdh_clk domain
//     raddr_o        out  BRAM read address
//     rdata_i        in   BRAM read data, valid one cycle after raddr_o
//     m_axis_tdata   out  stream data
//     m_axis_tvalid  out  stream valid
//     m_axis_tready  in   stream ready
//     m_axis_tlast   out  last beat of the capture (or of an aborted one)
//     dma_done_o     out  capture fully delivered
//     stall_cnt_o    out  (macro only) backpressure cycle count
// -----------------------------------------------------------------------------
module bram_stream_reader
  import pdh_pkg::*;
#(
  parameter int DEPTH = 16384,
  // A DEPTH of 1 still needs a 1-bit address port.
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              axi_clk,
  input  logic              rst_ni,
  input  logic              dma_enable_i,
  output logic [AW-1:0]     raddr_o,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              dma_done_o
`ifdef BRAM_READER_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic          en_s;
  reader_state_t state_r;
  reader_state_t state_nxt;

  logic [AW-1:0]     rd_addr_r;
  logic              inflight_r;
  logic              inflight_last_r;
  logic [DATA_W-1:0] fifo_data_r [2];
  logic              fifo_last_r [2];
  logic              rd_ptr_r;
  logic              wr_ptr_r;
  logic [1:0]        count_r;
  logic              force_last_r;
  logic              done_r;

  logic              tvalid_s;
  logic              pop_s;
  logic              push_s;
  logic              issue_s;
  logic              abort_s;
  logic              start_s;
  logic [2:0]        occ_s;

  sync_2ff #(.WIDTH(1)) u_en_sync (
    .clk    (axi_clk),
    .rst_ni (rst_ni),
    .d      (dma_enable_i),
    .q      (en_s)
  );

  assign tvalid_s = (count_r != 2'd0);
  assign pop_s    = tvalid_s & m_axis_tready;
  // Slots that will be occupied after this cycle if nothing new is issued.
  assign occ_s    = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};

  // FSM state register
  always_ff @(posedge axi_clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state, read-issue and abort decode
  always_comb begin
    state_nxt = state_r;
    issue_s   = 1'b0;
    abort_s   = 1'b0;
    start_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // An aborted beat still waiting for its handshake blocks a restart.
        if (en_s && (count_r == 2'd0)) begin
          state_nxt = ST_STREAM;
          start_s   = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (!en_s) begin
          abort_s   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          if (occ_s < 3'd2) begin
            issue_s = 1'b1;
          end else begin
            issue_s = 1'b0;
          end
          if (issue_s && (rd_addr_r == LAST_ADDR)) begin
            state_nxt = ST_DRAIN;
          end else begin
            state_nxt = ST_STREAM;
          end
        end
      end
      ST_DRAIN: begin
        if (!en_s) begin
          abort_s   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (pop_s && fifo_last_r[rd_ptr_r]) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (!en_s) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_DONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    // Data returning for a read issued before an abort is dropped.
    push_s = inflight_r & ~abort_s;
  end

  // Read address, in-flight tracking and the 2-entry output FIFO
  always_ff @(posedge axi_clk or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_addr_r       <= {AW{1'b0}};
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
      fifo_data_r[0]  <= {DATA_W{1'b0}};
      fifo_data_r[1]  <= {DATA_W{1'b0}};
      fifo_last_r[0]  <= 1'b0;
      fifo_last_r[1]  <= 1'b0;
      rd_ptr_r        <= 1'b0;
      wr_ptr_r        <= 1'b0;
      count_r         <= 2'd0;
      force_last_r    <= 1'b0;
      done_r          <= 1'b0;
    end else begin
      // The sweep stops on an explicit compare, so the address never wraps.
      if (start_s) begin
        rd_addr_r <= {AW{1'b0}};
      end else if (issue_s && (rd_addr_r != LAST_ADDR)) begin
        rd_addr_r <= rd_addr_r + AW'(1);
      end else begin
        rd_addr_r <= rd_addr_r;
      end

      inflight_r      <= issue_s;
      inflight_last_r <= issue_s & (rd_addr_r == LAST_ADDR);

      if (push_s) begin
        fifo_data_r[wr_ptr_r] <= rdata_i;
        fifo_last_r[wr_ptr_r] <= inflight_last_r;
      end else begin
        fifo_data_r[wr_ptr_r] <= fifo_data_r[wr_ptr_r];
        fifo_last_r[wr_ptr_r] <= fifo_last_r[wr_ptr_r];
      end

      if (abort_s) begin
        if (tvalid_s && !pop_s) begin
          // Keep only the head; it leaves with tlast forced high.
          count_r      <= 2'd1;
          wr_ptr_r     <= ~rd_ptr_r;
          rd_ptr_r     <= rd_ptr_r;
          force_last_r <= 1'b1;
        end else begin
          count_r      <= 2'd0;
          rd_ptr_r     <= rd_ptr_r ^ pop_s;
          wr_ptr_r     <= rd_ptr_r ^ pop_s;
          force_last_r <= 1'b0;
        end
      end else begin
        count_r  <= count_r + {1'b0, push_s} - {1'b0, pop_s};
        wr_ptr_r <= wr_ptr_r ^ push_s;
        rd_ptr_r <= rd_ptr_r ^ pop_s;
        if (pop_s) begin
          force_last_r <= 1'b0;
        end else begin
          force_last_r <= force_last_r;
        end
      end

      done_r <= (state_nxt == ST_DONE);
    end
  end

`ifdef BRAM_READER_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  // Saturating backpressure counter, cleared at capture start
  always_ff @(posedge axi_clk or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_r <= 32'd0;
    end else if (start_s) begin
      stall_cnt_r <= 32'd0;
    end else if (tvalid_s && !m_axis_tready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt_o = stall_cnt_r;
`endif

  assign raddr_o       = rd_addr_r;
  assign m_axis_tdata  = fifo_data_r[rd_ptr_r];
  assign m_axis_tvalid = tvalid_s;
  // abort_s covers the one cycle before force_last_r takes over.
  assign m_axis_tlast  = tvalid_s & (fifo_last_r[rd_ptr_r] | force_last_r | abort_s);
  assign dma_done_o    = done_r;

endmodule

// File: tb/tb_bram_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_bram_stream_reader
//   Directed bench: a DEPTH=8 reader and a DEPTH=1 reader, each fed by a
//   behavioural BRAM whose word equals its address.
// -----------------------------------------------------------------------------
module tb_bram_stream_reader;

  logic clk;
  logic rst_n;

  logic        en8, tready8, tvalid8, tlast8, done8;
  logic [2:0]  raddr8;
  logic [63:0] rdata8, tdata8;

  logic        en1, tready1, tvalid1, tlast1, done1;
  logic [0:0]  raddr1;
  logic [63:0] rdata1, tdata1;

`ifdef BRAM_READER_STALL_CNT_EN
  logic [31:0] stall8, stall1;
`endif

  int err_cnt;
  int chk_cnt;
  int stall_seen;

  // Fixed backpressure pattern, indexed by cycle count
  logic [15:0] pat;

  bram_stream_reader #(.DEPTH(8)) u_dut8 (
    .axi_clk       (clk),
    .rst_ni        (rst_n),
    .dma_enable_i  (en8),
    .raddr_o       (raddr8),
    .rdata_i       (rdata8),
    .m_axis_tdata  (tdata8),
    .m_axis_tvalid (tvalid8),
    .m_axis_tready (tready8),
    .m_axis_tlast  (tlast8),
    .dma_done_o    (done8)
`ifdef BRAM_READER_STALL_CNT_EN
    ,
    .stall_cnt_o   (stall8)
`endif
  );

  bram_stream_reader #(.DEPTH(1)) u_dut1 (
    .axi_clk       (clk),
    .rst_ni        (rst_n),
    .dma_enable_i  (en1),
    .raddr_o       (raddr1),
    .rdata_i       (rdata1),
    .m_axis_tdata  (tdata1),
    .m_axis_tvalid (tvalid1),
    .m_axis_tready (tready1),
    .m_axis_tlast  (tlast1),
    .dma_done_o    (done1)
`ifdef BRAM_READER_STALL_CNT_EN
    ,
    .stall_cnt_o   (stall1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM models: one-cycle read latency, word = address
  always @(posedge clk) begin
    rdata8 <= {61'd0, raddr8};
    rdata1 <= {63'd0, raddr1};
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full capture on the DEPTH=8 reader; called right after a negedge.
  task automatic sweep8(input bit use_pat);
    int idx = 0;
    int cyc = 0;
    int first_valid = -1;
    int first_hs = -1;
    int last_hs = -1;
    bit stalled = 1'b0;
    logic [63:0] held = 64'd0;
    stall_seen = 0;
    en8 = 1'b1;
    while (idx < 8 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        check_eq("stall_tdata_stable", tdata8, held);
        check_eq("stall_tvalid_held", 64'(tvalid8), 64'd1);
      end
      if (tvalid8 && first_valid < 0) first_valid = cyc;
      tready8 = use_pat ? pat[cyc % 16] : 1'b1;
      stalled = tvalid8 && !tready8;
      if (stalled) begin
        held = tdata8;
        stall_seen++;
      end
      if (tvalid8 && tready8) begin
        check_eq("beat_data", tdata8, 64'(idx));
        check_eq("beat_last", 64'(tlast8), 64'(idx == 7));
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        idx++;
      end
    end
    check_eq("sweep_beats", 64'(idx), 64'd8);
    if (!use_pat) begin
      // 2 sync flops + state entry + BRAM read + FIFO push
      check_eq("first_valid_latency", 64'(first_valid), 64'd5);
      check_eq("beats_back_to_back", 64'(last_hs - first_hs), 64'd7);
    end
    @(negedge clk);
    check_eq("done_after_last", 64'(done8), 64'd1);
    check_eq("tvalid_after_last", 64'(tvalid8), 64'd0);
`ifdef BRAM_READER_STALL_CNT_EN
    check_eq("stall_cnt", 64'(stall8), 64'(stall_seen));
`endif
    tready8 = 1'b0;
  endtask

  // Drop enable and check the done level falls on the third edge.
  task automatic end_capture8();
    en8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("done_hold_2", 64'(done8), 64'd1);
    @(negedge clk);
    check_eq("done_fall_3", 64'(done8), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int idx;
    int cyc;
    bit done_seen;
    logic [2:0] addr_hold;

    err_cnt = 0;
    chk_cnt = 0;
    pat     = 16'b1011_0010_1101_0110;
    en8 = 1'b0; tready8 = 1'b0;
    en1 = 1'b0; tready1 = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_raddr", 64'(raddr8), 64'd0);
    check_eq("rst_tvalid", 64'(tvalid8), 64'd0);
    check_eq("rst_tlast", 64'(tlast8), 64'd0);
    check_eq("rst_tdata", tdata8, 64'd0);
    check_eq("rst_done", 64'(done8), 64'd0);
`ifdef BRAM_READER_STALL_CNT_EN
    check_eq("rst_stall_cnt", 64'(stall8), 64'd0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Capture 1: tready held high
    sweep8(1'b0);
    end_capture8();

    // Capture 2: patterned backpressure
    sweep8(1'b1);
    end_capture8();

    // Capture 3: back-to-back again, stall counter must have cleared
    sweep8(1'b0);
    end_capture8();

    // Abort: enable dropped with tready low after three beats
    en8 = 1'b1; tready8 = 1'b1; idx = 0; cyc = 0;
    while (idx < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (tvalid8) begin
        check_eq("abort_pre_data", tdata8, 64'(idx));
        idx++;
      end
    end
    @(negedge clk);
    tready8 = 1'b0;
    en8 = 1'b0;
    check_eq("abort_pending_valid", 64'(tvalid8), 64'd1);
    check_eq("abort_pending_data", tdata8, 64'd3);
    repeat (4) @(negedge clk);
    check_eq("abort_hold_valid", 64'(tvalid8), 64'd1);
    check_eq("abort_hold_data", tdata8, 64'd3);
    check_eq("abort_hold_tlast", 64'(tlast8), 64'd1);
    addr_hold = raddr8;
    tready8 = 1'b1;
    @(negedge clk);
    check_eq("abort_after_hs_valid", 64'(tvalid8), 64'd0);
    done_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done8) done_seen = 1'b1;
    end
    check_eq("abort_no_done", 64'(done_seen), 64'd0);
    check_eq("abort_raddr_stopped", 64'(raddr8), 64'(addr_hold));
    check_eq("abort_idle_valid", 64'(tvalid8), 64'd0);
    tready8 = 1'b0;

    // Reset in the middle of a sweep, then a clean sweep from address 0
    en8 = 1'b1; tready8 = 1'b1; idx = 0; cyc = 0;
    while (idx < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (tvalid8) idx++;
    end
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_tvalid", 64'(tvalid8), 64'd0);
    check_eq("midrst_tlast", 64'(tlast8), 64'd0);
    check_eq("midrst_done", 64'(done8), 64'd0);
    check_eq("midrst_raddr", 64'(raddr8), 64'd0);
    en8 = 1'b0; tready8 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    sweep8(1'b0);
    end_capture8();

    // DEPTH=1: a single beat carrying tlast, then done
    en1 = 1'b1; tready1 = 1'b1; idx = 0; cyc = 0;
    while (idx < 1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (tvalid1) begin
        check_eq("d1_data", tdata1, 64'd0);
        check_eq("d1_tlast", 64'(tlast1), 64'd1);
        idx++;
      end
    end
    check_eq("d1_beats", 64'(idx), 64'd1);
    @(negedge clk);
    check_eq("d1_done", 64'(done1), 64'd1);
    check_eq("d1_tvalid_after", 64'(tvalid1), 64'd0);
    en1 = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("d1_done_fall", 64'(done1), 64'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
